// File: rtl/prg_uploader.sv
// Streams the in-memory BASIC program from RAM back to the HPS over the ioctl
// upload protocol. It reads the program-end pointer, requests an upload, then serves byte reads.
module prg_uploader #(
  parameter logic [15:0] PTR_ADDR  = 16'h55E4,
  parameter logic [15:0] PRG_START = 16'h5608,
  parameter logic [23:0] TIMEOUT   = 24'd10738636
) (
  input  logic        clk_vdp,
  input  logic        reset,
  input  logic        start,
  input  logic        ioctl_upload,
  input  logic        ioctl_rd,
  input  logic [24:0] ioctl_addr,
  output logic        ioctl_upload_req,
  output logic [7:0]  ioctl_din,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic [15:0] upload_len,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD_LO  = 3'd1;
  localparam logic [2:0] S_RD_GAP = 3'd2;
  localparam logic [2:0] S_RD_HI  = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_REQ    = 3'd5;
  localparam logic [2:0] S_STREAM = 3'd6;
  localparam logic [2:0] S_FETCH  = 3'd7;

  logic [2:0]  state;
  logic        start_d;
  logic [7:0]  end_lo;
  logic [7:0]  end_hi;
  logic [15:0] fetch_addr;
  logic [23:0] tcount;
  logic [15:0] prg_end;

  assign prg_end = {end_hi, end_lo};

  // Decoded from state so that an asynchronous reset clears every RAM/HPS request at once.
  always_comb begin
    mem_rd           = 1'b0;
    mem_addr         = 16'h0000;
    ioctl_upload_req = 1'b0;
    busy             = (state != S_IDLE);
    case (state)
      S_RD_LO: begin
        mem_rd   = 1'b1;
        mem_addr = PTR_ADDR;
      end
      S_RD_HI: begin
        mem_rd   = 1'b1;
        mem_addr = PTR_ADDR + 16'd1;
      end
      S_FETCH: begin
        mem_rd   = 1'b1;
        mem_addr = fetch_addr;
      end
      S_REQ: ioctl_upload_req = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_vdp or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      start_d    <= 1'b0;
      end_lo     <= 8'h00;
      end_hi     <= 8'h00;
      fetch_addr <= 16'h0000;
      tcount     <= 24'd0;
      upload_len <= 16'h0000;
      ioctl_din  <= 8'h00;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      start_d <= start;
      done    <= 1'b0;
      error   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !start_d) begin
            upload_len <= 16'h0000;
            state      <= S_RD_LO;
          end
        end
        S_RD_LO: begin
          if (mem_ack) begin
            end_lo <= mem_data;
            state  <= S_RD_GAP;
          end
        end
        S_RD_GAP: state <= S_RD_HI;
        S_RD_HI: begin
          if (mem_ack) begin
            end_hi <= mem_data;
            state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (prg_end <= PRG_START) begin
            error      <= 1'b1;
            upload_len <= 16'h0000;
            state      <= S_IDLE;
          end else begin
            upload_len <= prg_end - PRG_START;
            tcount     <= 24'd0;
            state      <= S_REQ;
          end
        end
        S_REQ: begin
          if (ioctl_upload) begin
            state <= S_STREAM;
          end else if (tcount == TIMEOUT - 24'd1) begin
            error <= 1'b1;
            state <= S_IDLE;
          end else begin
            tcount <= tcount + 24'd1;
          end
        end
        // A falling ioctl_upload ends the transfer and takes priority over a read strobe.
        S_STREAM: begin
          if (!ioctl_upload) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end else if (ioctl_rd) begin
            if (ioctl_addr < {9'd0, upload_len}) begin
              fetch_addr <= PRG_START + ioctl_addr[15:0];
              state      <= S_FETCH;
            end else begin
              ioctl_din <= 8'hFF;
            end
          end
        end
        S_FETCH: begin
          if (!ioctl_upload) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end else if (mem_ack) begin
            ioctl_din <= mem_data;
            state     <= S_STREAM;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prg_uploader.sv
// Self-checking bench for prg_uploader: a behavioural RAM with adjustable ack latency,
// a table of HPS read vectors, and directed sequences for error, timeout and reset cases.
module tb_prg_uploader;

  localparam logic [15:0] PTR = 16'h55E4;
  localparam logic [15:0] PRG = 16'h5608;

  logic        clk_vdp;
  logic        reset;
  logic        start;
  logic        ioctl_upload;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic        ioctl_upload_req;
  logic [7:0]  ioctl_din;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_data = 8'h00;
  logic [15:0] upload_len;
  logic        busy;
  logic        done;
  logic        error;

  prg_uploader #(
    .PTR_ADDR (PTR),
    .PRG_START(PRG),
    .TIMEOUT  (24'd100)
  ) dut (
    .clk_vdp         (clk_vdp),
    .reset           (reset),
    .start           (start),
    .ioctl_upload    (ioctl_upload),
    .ioctl_rd        (ioctl_rd),
    .ioctl_addr      (ioctl_addr),
    .ioctl_upload_req(ioctl_upload_req),
    .ioctl_din       (ioctl_din),
    .mem_rd          (mem_rd),
    .mem_addr        (mem_addr),
    .mem_ack         (mem_ack),
    .mem_data        (mem_data),
    .upload_len      (upload_len),
    .busy            (busy),
    .done            (done),
    .error           (error)
  );

  initial clk_vdp = 1'b0;
  always #5 clk_vdp = ~clk_vdp;

  // Behavioural RAM: acks ack_lat cycles after mem_rd is first seen
  logic [7:0] ram [0:65535];
  int ack_lat = 1;
  int ack_cnt = 0;
  always @(posedge clk_vdp) begin
    mem_ack <= 1'b0;
    if (!mem_rd || mem_ack) begin
      ack_cnt <= 0;
    end else if (ack_cnt >= ack_lat - 1) begin
      mem_ack  <= 1'b1;
      mem_data <= ram[mem_addr];
      ack_cnt  <= 0;
    end else begin
      ack_cnt <= ack_cnt + 1;
    end
  end

  int cyc = 0, done_cnt = 0, err_cnt = 0, req_cyc = 0, rd_cyc = 0, stab_err = 0, last_ack_cyc = 0;
  logic [15:0] last_ack_addr = 16'h0000;
  logic [15:0] prev_addr = 16'h0000;
  logic        prev_rd = 1'b0;
  always @(negedge clk_vdp) begin
    cyc = cyc + 1;
    if (done) done_cnt = done_cnt + 1;
    if (error) err_cnt = err_cnt + 1;
    if (ioctl_upload_req) req_cyc = req_cyc + 1;
    if (mem_rd) rd_cyc = rd_cyc + 1;
    if (mem_ack) begin
      last_ack_cyc  = cyc;
      last_ack_addr = mem_addr;
    end
    if (mem_rd && prev_rd && mem_addr != prev_addr) stab_err = stab_err + 1;
    prev_rd   = mem_rd;
    prev_addr = mem_addr;
  end

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  din;
    logic        fetch;
  } vec_t;
  vec_t vecs [12];

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_vdp);
      #1;
    end
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic waitReq(input logic lvl, input int bound, input string name);
    int n = 0;
    while (ioctl_upload_req !== lvl && n < bound) begin
      tick(1);
      n++;
    end
    checkOutput(name, 32'(ioctl_upload_req), 32'(lvl));
  endtask

  task automatic waitIdle(input int bound, input string name);
    int n = 0;
    while (busy !== 1'b0 && n < bound) begin
      tick(1);
      n++;
    end
    checkOutput(name, 32'(busy), 32'd0);
  endtask

  task automatic setPointer(input logic [15:0] endp);
    ram[PTR]         = endp[7:0];
    ram[PTR + 16'd1] = endp[15:8];
  endtask

  task automatic startUpload(input logic [15:0] endp, input string tag);
    setPointer(endp);
    pulseStart();
    waitReq(1'b1, 60, {tag, "_req_rise"});
    ioctl_upload = 1'b1;
    waitReq(1'b0, 5, {tag, "_req_drop"});
  endtask

  task automatic applyStimulus(input logic [24:0] addr);
    ioctl_addr = addr;
    ioctl_rd   = 1'b1;
    tick(1);
    ioctl_rd   = 1'b0;
    tick(12);
  endtask

  task automatic runTable(input string tag);
    int rc;
    for (int i = 0; i < 12; i++) begin
      rc = rd_cyc;
      applyStimulus(vecs[i].addr);
      checkOutput($sformatf("%s_din[%0d]", tag, i), 32'(ioctl_din), 32'(vecs[i].din));
      checkOutput($sformatf("%s_fetch[%0d]", tag, i), 32'(rd_cyc != rc), 32'(vecs[i].fetch));
      if (vecs[i].fetch)
        checkOutput($sformatf("%s_addr[%0d]", tag, i), 32'(last_ack_addr),
                    32'(PRG + vecs[i].addr[15:0]));
    end
  endtask

  task automatic endUpload(input string tag);
    int d0;
    d0 = done_cnt;
    ioctl_upload = 1'b0;
    tick(3);
    checkOutput({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_len_kept"}, 32'(upload_len), 32'd8);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int d0, e0, r0, rc;

    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    for (int i = 0; i < 8; i++) ram[PRG + 16'(i)] = 8'(i + 1);
    ram[PRG + 16'd8] = 8'hAA;
    for (int i = 0; i < 8; i++) vecs[i] = '{25'(i), 8'(i + 1), 1'b1};
    vecs[8]  = '{25'd8,       8'hFF, 1'b0};
    vecs[9]  = '{25'h10000,   8'hFF, 1'b0};
    vecs[10] = '{25'd3,       8'h04, 1'b1};
    vecs[11] = '{25'h10003,   8'hFF, 1'b0};

    reset = 1'b1; start = 1'b0; ioctl_upload = 1'b0; ioctl_rd = 1'b0; ioctl_addr = '0;
    tick(2);
    checkOutput("reset_outputs",
                32'({ioctl_upload_req, ioctl_din, mem_rd, upload_len, busy, done, error}), 32'd0);
    checkOutput("reset_mem_addr", 32'(mem_addr), 32'd0);
    reset = 1'b0;
    tick(2);

    // Normal save with a 1-cycle RAM
    ack_lat = 1;
    e0 = err_cnt;
    startUpload(16'h5610, "normal");
    checkOutput("normal_len", 32'(upload_len), 32'd8);
    runTable("normal");
    checkOutput("normal_no_error", 32'(err_cnt - e0), 32'd0);
    endUpload("normal");

    // Empty program: end pointer equal to the start address
    setPointer(16'h5608);
    e0 = err_cnt; r0 = req_cyc;
    pulseStart();
    waitIdle(40, "empty_idle");
    checkOutput("empty_idle_latency", 32'((cyc - last_ack_cyc) <= 6), 32'd1);
    tick(1);
    checkOutput("empty_error", 32'(err_cnt - e0), 32'd1);
    checkOutput("empty_no_req", 32'(req_cyc - r0), 32'd0);
    checkOutput("empty_len", 32'(upload_len), 32'd0);

    // Timeout with a one-byte program
    setPointer(16'h5609);
    e0 = err_cnt; r0 = req_cyc;
    pulseStart();
    waitReq(1'b1, 60, "timeout_req_rise");
    waitIdle(200, "timeout_idle");
    tick(1);
    checkOutput("timeout_req_cycles", 32'(req_cyc - r0), 32'd100);
    checkOutput("timeout_error", 32'(err_cnt - e0), 32'd1);
    checkOutput("timeout_len", 32'(upload_len), 32'd1);

    // Slow RAM, start re-pulsed during STREAM, then a fall coinciding with a read
    ack_lat = 5;
    startUpload(16'h5610, "slow");
    rc = rd_cyc;
    pulseStart();
    tick(5);
    checkOutput("slow_start_ignored_busy", 32'(busy), 32'd1);
    checkOutput("slow_start_ignored_rd", 32'(rd_cyc - rc), 32'd0);
    runTable("slow");
    checkOutput("slow_addr_stable", 32'(stab_err), 32'd0);
    d0 = done_cnt; rc = rd_cyc;
    ioctl_addr = 25'd0; ioctl_rd = 1'b1; ioctl_upload = 1'b0;
    tick(1);
    ioctl_rd = 1'b0;
    tick(8);
    checkOutput("fall_rd_no_fetch", 32'(rd_cyc - rc), 32'd0);
    checkOutput("fall_rd_done", 32'(done_cnt - d0), 32'd1);
    checkOutput("fall_rd_busy", 32'(busy), 32'd0);

    // Reset while a fetch is pending
    startUpload(16'h5610, "rstfetch");
    ioctl_addr = 25'd2; ioctl_rd = 1'b1;
    tick(1);
    ioctl_rd = 1'b0;
    tick(2);
    checkOutput("rstfetch_in_fetch", 32'(mem_rd), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("rstfetch_outputs",
                32'({ioctl_upload_req, ioctl_din, mem_rd, upload_len, busy, done, error}), 32'd0);
    checkOutput("rstfetch_mem_addr", 32'(mem_addr), 32'd0);
    ioctl_upload = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(2);
    ack_lat = 1;
    startUpload(16'h5610, "after_rst");
    checkOutput("after_rst_len", 32'(upload_len), 32'd8);
    runTable("after_rst");
    endUpload("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prg_uploader.md
Name: prg_uploader

Overview:
- Reader counterpart of the PRG downloader: streams the in-memory BASIC program from on-chip RAM back to the HPS over the ioctl upload protocol, so a running program can be saved as a .PRG file.
- Reads the program-end pointer, computes the length, requests an upload, then serves HPS byte reads from a dedicated RAM read port.
- Sits beside the downloader and eraser in the emu top level, in the clk_vdp domain.

Parameters:
- PTR_ADDR, 16'h55E4, RAM address of the little-endian program-end pointer.
- PRG_START, 16'h5608, RAM address of the first program byte; upload offset 0 maps here.
- TIMEOUT, 24'd10738636, clk_vdp cycles to wait for ioctl_upload after a request (about 1 s).

Ports:
- clk_vdp  in  1  block clock.
- reset  in  1  reset, asynchronous, active-high.
- start  in  1  save trigger from the OSD; rising edge is detected internally.
- ioctl_upload  in  1  HPS upload active, level.
- ioctl_rd  in  1  HPS byte-read strobe, 1 cycle.
- ioctl_addr  in  25  byte offset for ioctl_rd.
- ioctl_upload_req  out  1  upload request to the HPS.
- ioctl_din  out  8  byte returned to the HPS.
- mem_rd  out  1  RAM read request, level.
- mem_addr  out  16  RAM read address.
- mem_ack  in  1  RAM data valid, 1 cycle, arrives at least 1 cycle after mem_rd.
- mem_data  in  8  RAM read data, valid with mem_ack.
- upload_len  out  16  program length in bytes.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  1-cycle pulse when an upload completes.
- error  out  1  1-cycle pulse on empty program or timeout.

Behaviour:
- Reset is asynchronous and active-high, with clock clk_vdp.
- Reset values: every output 0; state IDLE; start edge register 0. Reset mid-operation aborts immediately; ioctl_upload_req drops in the same event.
- The ioctl_* signals are synchronous to clk_vdp.

State machine:
- IDLE: a rising edge of start enters RD_LO. Start edges are ignored in every other state.
- RD_LO: mem_addr=PTR_ADDR, mem_rd=1. On mem_ack, latch the low byte, drop mem_rd for 1 cycle, go to RD_HI.
- RD_HI: mem_addr=PTR_ADDR+1, mem_rd=1. On mem_ack, latch the high byte and go to CHECK.
- CHECK (1 cycle): end = {hi,lo}.
  - If end <= PRG_START: pulse error, set upload_len=0, go to IDLE.
  - Otherwise set upload_len = end - PRG_START (16-bit, cannot overflow) and go to REQ.
- REQ: ioctl_upload_req=1 and the timeout counter is cleared on entry.
  - When ioctl_upload is high, drop the request and go to STREAM.
  - If the counter reaches TIMEOUT-1 first, drop the request, pulse error, go to IDLE.
- STREAM, on ioctl_rd:
  - If ioctl_addr < upload_len: mem_addr = PRG_START + ioctl_addr[15:0] (16-bit wrap), mem_rd=1, go to FETCH.
  - If ioctl_addr >= upload_len, including any bit [24:16] set: ioctl_din=8'hFF the next cycle, no RAM access.
- FETCH: hold mem_rd and mem_addr until mem_ack. Load ioctl_din from mem_data on the ack cycle, drop mem_rd, return to STREAM. ioctl_din holds its value until the next load.
- Read-serving rules:
  - Latency from ioctl_rd to valid ioctl_din = 1 + RAM ack latency.
  - The HPS does not issue the next ioctl_rd sooner than 4 cycles.
  - An ioctl_rd arriving while in FETCH is ignored.
- ioctl_upload falling in STREAM or FETCH: abort any pending mem_rd, pulse done, go to IDLE. upload_len is retained until the next start.
- ioctl_upload falling on the same cycle as ioctl_rd: the fall wins and no fetch starts.
- mem_rd is never asserted outside RD_LO, RD_HI and FETCH.

Test Plan:
- Normal save: RAM[55E4]=10, RAM[55E5]=56 (end 5610), program bytes 01..08. Pulse start, raise ioctl_upload, issue ioctl_rd at offsets 0..7, then drop upload.
  - Required: upload_len=8, ioctl_din sequence 01..08, single done pulse, mem_addr 5608..560F.
- Empty program: pointer 5608.
  - Required: error pulse, ioctl_upload_req never asserts, busy returns low within 6 cycles of the last ack.
- Timeout: valid pointer, ioctl_upload held low.
  - Required: ioctl_upload_req high for exactly TIMEOUT cycles, then error pulse, state IDLE. Use TIMEOUT=100 in the bench.
- Out-of-range read: upload_len=8, ioctl_rd at offsets 8 and 25'h10000.
  - Required: ioctl_din=FF and no mem_rd.
- Slow RAM: mem_ack delayed 5 cycles, plus a start re-pulsed during STREAM.
  - Required: correct data, start ignored, mem_addr stable while mem_rd is high.
- Reset mid-FETCH: assert reset.
  - Required: all outputs 0 immediately. After release, a new start performs a full correct upload.
